// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - load/store sequencer driving the word-addressed data memory.
// Optional out-of-range checking is enabled by defining DM_BOUNDS_CHK_EN.
module dm_access_ctrl #(
    parameter int RD_WAIT   = 1,
    parameter int WE_PULSE  = 1,
    parameter int MEM_WORDS = 65533
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] dm_read_addr,
    output logic [15:0] dm_write_addr,
    output logic [31:0] dm_write_data,
    output logic        dm_we,
    input  logic [31:0] dm_read_data
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_WAIT = 3'd1;
    localparam logic [2:0] S_WR_HI   = 3'd2;
    localparam logic [2:0] S_WR_LO   = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;
`ifdef DM_BOUNDS_CHK_EN
    localparam logic [2:0] S_ERR     = 3'd5;
`endif

    logic [2:0]  state;
    logic [15:0] cnt;
    logic        accept;
    logic        addr_oob;

    assign req_ready = (state == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

`ifdef DM_BOUNDS_CHK_EN
    logic err_q;
    assign addr_oob = ({1'b0, req_addr} >= 17'(MEM_WORDS));
    assign resp_err = err_q;
`else
    assign addr_oob = 1'b0;
    assign resp_err = 1'b0;
    // Without the check MEM_WORDS only documents the attached memory size.
    if (MEM_WORDS > 65536) begin : g_mem_words_exceeds_addr_space
    end
`endif

    // No reset here: a reset that cuts a WR_HI pulse must commit the store's own word.
    always_ff @(posedge clk) begin
        if (accept && req_we && !addr_oob) begin
            dm_write_addr <= req_addr;
            dm_write_data <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= 16'd0;
            dm_we        <= 1'b0;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'd0;
            dm_read_addr <= 16'd0;
`ifdef DM_BOUNDS_CHK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
`ifdef DM_BOUNDS_CHK_EN
                        if (addr_oob) begin
                            state <= S_ERR;
                        end else
`endif
                        if (req_we) begin
                            dm_we <= 1'b1;
                            cnt   <= 16'(WE_PULSE - 1);
                            state <= S_WR_HI;
                        end else begin
                            dm_read_addr <= req_addr;
                            cnt          <= 16'(RD_WAIT - 1);
                            state        <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (cnt == 16'd0) begin
                        resp_rdata <= dm_read_data;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_WR_HI: begin
                    if (cnt == 16'd0) begin
                        dm_we <= 1'b0;
                        cnt   <= 16'd1;
                        state <= S_WR_LO;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                // Settle covers the falling-edge commit plus one quiet cycle: WE_PULSE+2 total.
                S_WR_LO: begin
                    if (cnt == 16'd0) begin
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_RESP: begin
                    resp_valid <= 1'b0;
`ifdef DM_BOUNDS_CHK_EN
                    err_q      <= 1'b0;
`endif
                    state      <= S_IDLE;
                end
`ifdef DM_BOUNDS_CHK_EN
                S_ERR: begin
                    resp_valid <= 1'b1;
                    err_q      <= 1'b1;
                    resp_rdata <= 32'd0;
                    state      <= S_RESP;
                end
`endif
                default: begin
                    dm_we      <= 1'b0;
                    resp_valid <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
